// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared encodings, record bytes and state constants for the result sender
package sad_pkg;

  localparam logic [1:0] SEND_IDLE    = 2'b00;
  localparam logic [1:0] SEND_MATCH   = 2'b01;
  localparam logic [1:0] SEND_NOMATCH = 2'b10;
  localparam logic [1:0] SEND_DONE    = 2'b11;

  localparam logic [7:0] REC_MATCH    = 8'h4D;
  localparam logic [7:0] REC_NOMATCH  = 8'h4E;
  localparam logic [7:0] REC_DONE     = 8'h44;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic logic [7:0] record_header(input logic [1:0] code);
    case (code)
      SEND_MATCH:   return REC_MATCH;
      SEND_NOMATCH: return REC_NOMATCH;
      default:      return REC_DONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with load/done handshake and registered line
module uart_tx_byte
  import sad_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam logic [11:0] BAUD_MAX = 12'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [11:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_MAX);
  // Asserted in the last cycle of the stop bit so a following load starts the next frame seamlessly.
  assign o_done    = (r_state == ST_STOP) && w_bit_end;
  assign o_tx      = r_tx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_baud  <= 12'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else if (i_load) begin
      r_state <= ST_START;
      r_baud  <= 12'd0;
      r_bit   <= 3'd0;
      r_shift <= i_data;
      r_tx    <= 1'b0;
    end else begin
      r_baud <= w_bit_end ? 12'd0 : r_baud + 12'd1;
      case (r_state)
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_baud  <= 12'd0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_result_sender.sv
// rtl/uart_result_sender.sv - sequences match/no-match/done records onto the UART serializer
module uart_result_sender
  import sad_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  UARTsend,
  input  logic [11:0] ROMtoRead,
  output logic        UARTsendComplete,
  output logic        UARTtx,
  output logic        busy
);

  state_t      r_state;
  logic        r_armed;
  logic [1:0]  r_code;
  logic [11:0] r_addr;
  logic [1:0]  r_byte_idx;

  logic        w_accept;
  logic        w_last;
  logic        w_byte_done;
  logic        w_load;
  logic [7:0]  w_next_byte;
  logic [7:0]  w_load_data;

  assign w_accept    = (r_state == ST_IDLE) && r_armed && (UARTsend != SEND_IDLE);
  assign w_last      = (r_code != SEND_MATCH) || (r_byte_idx == 2'd2);
  assign w_next_byte = (r_byte_idx == 2'd0) ? {4'h0, r_addr[11:8]} : r_addr[7:0];
  // The header byte comes straight from the request so the start bit begins one edge after acceptance.
  assign w_load      = w_accept || ((r_state == ST_DATA) && w_byte_done && !w_last);
  assign w_load_data = w_accept ? record_header(UARTsend) : w_next_byte;

  assign busy             = (r_state != ST_IDLE);
  assign UARTsendComplete = (r_state == ST_DONE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_data (w_load_data),
    .o_tx   (UARTtx),
    .o_done (w_byte_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_code     <= SEND_IDLE;
      r_addr     <= 12'd0;
      r_byte_idx <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_DATA;
            r_armed    <= 1'b0;
            r_code     <= UARTsend;
            r_addr     <= ROMtoRead;
            r_byte_idx <= 2'd0;
          end else if (UARTsend == SEND_IDLE) begin
            r_armed <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
